// File: rtl/cntdown_timer_mc_pkg.sv
// Shared definitions for the multi-channel countdown timer: button actions and
// modular add/subtract helpers used by every channel.
package cntdown_pkg;

   localparam int unsigned SEC_PER_MIN = 32'd60;

   typedef enum logic [2:0] {
      ACT_NONE    = 3'd0,
      ACT_RUN     = 3'd1,
      ACT_CLR     = 3'd2,
      ACT_MIN_INC = 3'd3,
      ACT_MIN_DEC = 3'd4,
      ACT_SEC_INC = 3'd5,
      ACT_SEC_DEC = 3'd6
   } act_e;

   // a + b folded back into 0..m-1; inputs are already below m, so one subtract suffices
   function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m);
      logic [31:0] s;
      s = a + b;
      if (s >= m) return s - m;
      else        return s;
   endfunction

   function automatic logic [31:0] wrap_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] m);
      if (a >= b) return a - b;
      else        return a + m - b;
   endfunction

endpackage

// File: rtl/cntdown_timer_mc_if.sv
// Button/strobe inputs and per-channel status outputs of the countdown timer.
interface cntdown_timer_mc_if #(
   parameter int MAX_VAL  = 6000,
   parameter int CHANNELS = 4,
   parameter int BITS_NUM = $clog2(MAX_VAL),
   parameter int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic                CE;
   logic                RUN_CE;
   logic [SEL_BITS-1:0] SEL;
   logic                BTN_RUN;
   logic                BTN_CLR;
   logic                BTN_MIN_INC;
   logic                BTN_MIN_DEC;
   logic                BTN_SEC_INC;
   logic                BTN_SEC_DEC;
   logic                ACK;
   logic [BITS_NUM-1:0] Q;
   logic [CHANNELS-1:0] IS_RUNNING;
   logic [CHANNELS-1:0] ALARM;
   logic [CHANNELS-1:0] DONE;

   modport master (
      output CE, RUN_CE, SEL, BTN_RUN, BTN_CLR, BTN_MIN_INC, BTN_MIN_DEC,
             BTN_SEC_INC, BTN_SEC_DEC, ACK,
      input  Q, IS_RUNNING, ALARM, DONE
   );

   modport slave (
      input  CE, RUN_CE, SEL, BTN_RUN, BTN_CLR, BTN_MIN_INC, BTN_MIN_DEC,
             BTN_SEC_INC, BTN_SEC_DEC, ACK,
      output Q, IS_RUNNING, ALARM, DONE
   );
endinterface

// File: rtl/cntdown_timer_mc_channel.sv
// One countdown channel: value, run/alarm/done flags and, when
// CNTDOWN_TIMER_AUTO_RELOAD_EN is defined, the reload preset.
module cntdown_channel
   import cntdown_pkg::*;
#(
   parameter int MAX_VAL  = 6000,
   parameter int BITS_NUM = $clog2(MAX_VAL)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  act_e                act_i,
   input  logic                tick_i,
   input  logic                ack_i,
   output logic [BITS_NUM-1:0] value_o,
   output logic                running_o,
   output logic                alarm_o,
   output logic                done_o
);
   localparam logic [31:0]         MAX_W  = 32'(MAX_VAL);
   localparam logic [BITS_NUM-1:0] V_ZERO = {BITS_NUM{1'b0}};
   localparam logic [BITS_NUM-1:0] V_ONE  = {{(BITS_NUM-1){1'b0}}, 1'b1};

   logic [BITS_NUM-1:0] v_q, v_d;
   logic                run_q, run_d;
   logic                alarm_q, alarm_d;
   logic                done_q, done_d;
   logic [BITS_NUM-1:0] min_inc_s, min_dec_s, sec_inc_s, sec_dec_s;
   logic [BITS_NUM-1:0] expire_v_s;
   logic                expire_run_s;

   assign min_inc_s = BITS_NUM'(wrap_add(32'(v_q), SEC_PER_MIN, MAX_W));
   assign min_dec_s = BITS_NUM'(wrap_sub(32'(v_q), SEC_PER_MIN, MAX_W));
   assign sec_inc_s = BITS_NUM'(wrap_add(32'(v_q), 32'd1, MAX_W));
   assign sec_dec_s = BITS_NUM'(wrap_sub(32'(v_q), 32'd1, MAX_W));

`ifdef CNTDOWN_TIMER_AUTO_RELOAD_EN
   logic [BITS_NUM-1:0] preset_q, preset_d;

   assign expire_v_s   = preset_q;
   assign expire_run_s = 1'b1;

   // Preset is the value a stopped channel had when it was started
   always_comb begin
      if (!run_q && (act_i == ACT_RUN) && (v_q != V_ZERO)) preset_d = v_q;
      else                                                 preset_d = preset_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) preset_q <= V_ZERO;
      else        preset_q <= preset_d;
   end
`else
   assign expire_v_s   = V_ZERO;
   assign expire_run_s = 1'b0;
`endif

   // Tick first, then control, so a pause on a tick cycle still takes the decrement
   always_comb begin
      v_d     = v_q;
      run_d   = run_q;
      alarm_d = ack_i ? 1'b0 : alarm_q;
      done_d  = 1'b0;
      if (tick_i && run_q) begin
         if (v_q > V_ONE) begin
            v_d = v_q - V_ONE;
         end else if (v_q == V_ONE) begin
            v_d     = expire_v_s;
            run_d   = expire_run_s;
            alarm_d = 1'b1;
            done_d  = 1'b1;
         end else begin
            run_d = 1'b0;
         end
      end else begin
         done_d = 1'b0;
      end
      if (run_q) begin
         run_d = (act_i == ACT_RUN) ? 1'b0 : run_d;
      end else begin
         case (act_i)
            ACT_RUN: begin
               if (v_q != V_ZERO) begin
                  run_d   = 1'b1;
                  alarm_d = 1'b0;
               end else begin
                  run_d = run_q;
               end
            end
            ACT_CLR: begin
               v_d     = V_ZERO;
               alarm_d = 1'b0;
            end
            ACT_MIN_INC: v_d = min_inc_s;
            ACT_MIN_DEC: v_d = min_dec_s;
            ACT_SEC_INC: v_d = sec_inc_s;
            ACT_SEC_DEC: v_d = sec_dec_s;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= V_ZERO;
         run_q   <= 1'b0;
         alarm_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         v_q     <= v_d;
         run_q   <= run_d;
         alarm_q <= alarm_d;
         done_q  <= done_d;
      end
   end

   assign value_o   = v_q;
   assign running_o = run_q;
   assign alarm_o   = alarm_q;
   assign done_o    = done_q;

endmodule

// File: rtl/cntdown_timer_mc.sv
// Multi-channel countdown timer top: button priority encoder, SEL decode and Q mux
// over CHANNELS cntdown_channel instances. Auto-reload: CNTDOWN_TIMER_AUTO_RELOAD_EN.
module cntdown_timer_mc
   import cntdown_pkg::*;
#(
   parameter int MAX_VAL  = 6000,
   parameter int CHANNELS = 4,
   parameter int BITS_NUM = $clog2(MAX_VAL),
   parameter int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input logic              CLK,
   input logic              CLR_N,
   cntdown_timer_mc_if.slave bus
);
   act_e                act_s;
   logic [CHANNELS-1:0] sel_hit_s;
   logic [BITS_NUM-1:0] val_s [CHANNELS];
   logic [CHANNELS-1:0] running_s, alarm_s, done_s;
   logic [BITS_NUM-1:0] q_s;

   // One action per CE strobe, highest-priority button wins
   always_comb begin
      act_s = ACT_NONE;
      if (!bus.CE)                act_s = ACT_NONE;
      else if (bus.BTN_RUN)       act_s = ACT_RUN;
      else if (bus.BTN_CLR)       act_s = ACT_CLR;
      else if (bus.BTN_MIN_INC)   act_s = ACT_MIN_INC;
      else if (bus.BTN_MIN_DEC)   act_s = ACT_MIN_DEC;
      else if (bus.BTN_SEC_INC)   act_s = ACT_SEC_INC;
      else if (bus.BTN_SEC_DEC)   act_s = ACT_SEC_DEC;
      else                        act_s = ACT_NONE;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign sel_hit_s[c] = (32'(bus.SEL) == 32'(c));

      cntdown_channel #(
         .MAX_VAL  (MAX_VAL),
         .BITS_NUM (BITS_NUM)
      ) u_ch (
         .clk       (CLK),
         .rst_n     (CLR_N),
         .act_i     (sel_hit_s[c] ? act_s : ACT_NONE),
         .tick_i    (bus.RUN_CE),
         .ack_i     (bus.ACK && sel_hit_s[c]),
         .value_o   (val_s[c]),
         .running_o (running_s[c]),
         .alarm_o   (alarm_s[c]),
         .done_o    (done_s[c])
      );
   end

   // Display mux; an out-of-range SEL matches no channel and reads 0
   always_comb begin
      q_s = {BITS_NUM{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         q_s = sel_hit_s[c] ? val_s[c] : q_s;
      end
   end

   assign bus.Q          = q_s;
   assign bus.IS_RUNNING = running_s;
   assign bus.ALARM      = alarm_s;
   assign bus.DONE       = done_s;

endmodule

// File: doc/cntdown_timer_mc.md
# cntdown_timer_mc

Multi-channel successor to the single countdown timer: `CHANNELS` independent minute/second countdown channels sharing one button set. A channel-select input routes edits to one channel, and each channel latches an alarm on expiry. An optional auto-reload mode makes each channel a periodic timer. The block sits between the debounced button/prescaler logic (`CE`, `RUN_CE` strobes) and the display multiplexer, which reads the selected channel via `Q`.

## Interface
- `MAX_VAL`, default 6000: channel range in seconds; legal values 0..MAX_VAL-1. Must be a multiple of 60 and ≥120.
- `CHANNELS`, default 4: number of channels, 1..16.
- `BITS_NUM`, default $clog2(MAX_VAL): width of one channel value.
- `SEL_BITS`, default max(1,$clog2(CHANNELS)): width of `SEL`.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `CLR_N`  in  1  asynchronous, active-low reset.
- `CE`  in  1  control strobe; buttons are sampled only when high.
- `RUN_CE`  in  1  1 Hz tick strobe for all running channels.
- `SEL`  in  SEL_BITS  selected channel; values ≥CHANNELS select nothing.
- `BTN_RUN`, `BTN_CLR`, `BTN_MIN_INC`, `BTN_MIN_DEC`, `BTN_SEC_INC`, `BTN_SEC_DEC`  in  1 each  button strobes, applied to channel `SEL`.
- `ACK`  in  1  clears `ALARM[SEL]`.
- `Q`  out  BITS_NUM  value of channel `SEL`; combinational mux; 0 when `SEL` is out of range.
- `IS_RUNNING`  out  CHANNELS  per-channel run flag, registered.
- `ALARM`  out  CHANNELS  per-channel latched expiry flag, registered.
- `DONE`  out  CHANNELS  one-cycle expiry pulse, registered.

## Operation
- Reset: all channel values, presets, `IS_RUNNING`, `ALARM` and `DONE` are cleared to 0 immediately and stay 0 while `CLR_N`=0. Reset mid-count aborts without a `DONE` pulse.
- Tick (`RUN_CE`=1), applied to every running channel c:
  - V>1: V-1.
  - V==1: expiry. V becomes 0, `IS_RUNNING[c]` becomes 0, `ALARM[c]` becomes 1, and `DONE[c]` is 1 for exactly the next cycle.
  - V==0 while running (only reachable by preset 0): stop, no alarm.
- Control (`CE`=1), selected channel only. Exactly one action per strobe, in priority order RUN > CLR > MIN_INC > MIN_DEC > SEC_INC > SEC_DEC.
  - Running channel: `BTN_RUN` stops it (pause, value held). All other buttons are ignored.
  - Stopped channel, `BTN_RUN`: starts only if V>0. It then captures PRESET←V and clears `ALARM`. If V==0 it is ignored.
  - `BTN_CLR`: V←0 and `ALARM`←0.
  - MIN_INC: V+60, wrapping with subtract MAX_VAL if ≥MAX_VAL.
  - MIN_DEC: V≥60 ? V-60 : V+MAX_VAL-60.
  - SEC_INC: V==MAX_VAL-1 ? 0 : V+1.
  - SEC_DEC: V==0 ? MAX_VAL-1 : V-1.
  - All arithmetic is done in BITS_NUM+1 bits. No modulo operator is used.
- `ACK` acts independently of `CE`. Expiry in the same cycle as `ACK` wins, so `ALARM` stays 1.
- Simultaneous tick and control on the same running channel: decrement and stop both apply. If the tick expires the channel, the alarm is still set.
- Changing `SEL` never affects channel state.

## Timing
- Control, tick and `ACK` effects are visible on registered outputs 1 cycle after the strobe edge.
- `Q` follows `SEL` combinationally, with 0-cycle latency.
- `DONE` is high for one `CLK` cycle per expiry, independent of `CE`/`RUN_CE` duty.
- With `CE` held high, one action is applied per `CLK` cycle.

## Configuration
- `CNTDOWN_TIMER_AUTO_RELOAD_EN` defined: on expiry the value reloads from PRESET instead of 0, and `IS_RUNNING` stays 1. `ALARM` is set and `DONE` pulses as usual. This gives a periodic timer with period PRESET seconds.
- Macro undefined: expiry stops the channel at 0. Preset registers may be optimised out, and behaviour is otherwise identical.

## Structure
- Shared package `cntdown_pkg`: `SEC_PER_MIN`=60, action enum (ACT_NONE, ACT_RUN, ACT_CLR, ACT_MIN_INC, ACT_MIN_DEC, ACT_SEC_INC, ACT_SEC_DEC), and the wrap-add/wrap-sub helper functions.
- Top level holds the priority encoder and `SEL` decode, and produces per-channel action, tick and ack strobes.
- Sub-module `cntdown_channel` holds one channel's value, preset, run, alarm and done state. It is instantiated CHANNELS times via generate.

## Test plan
- Reset mid-count: ch2 running at 37, pull `CLR_N` low between edges -> all outputs 0 at once, no `DONE` pulse.
- Wrap arithmetic, ch0 (MAX_VAL=6000): start 0, SEC_DEC -> 5999; MIN_INC -> 59; MIN_DEC -> 5999; SEC_INC -> 0; MIN_DEC -> 5940.
- Priority: ch1=100 stopped, `BTN_MIN_INC`+`BTN_SEC_DEC`+`BTN_CLR` in one `CE` -> Q=0. Then all buttons with RUN at Q=0 -> ignored, still stopped.
- Expiry and alarm: ch3=2 started, 2 ticks -> Q=0, `IS_RUNNING[3]`=0, `DONE[3]` for 1 cycle, `ALARM[3]`=1. `ACK` on the expiry cycle -> `ALARM` stays 1. `ACK` later -> 0.
- Independence: ch0=5, ch1=3, both running, `SEL`=1, `BTN_RUN` at tick -> ch1 pauses at 2, ch0 continues to 4.
- Auto-reload (macro defined): ch0=3 started, 7 ticks -> values 2,1,3,2,1,3,2 with `DONE` on ticks 3 and 6, still running.
